// File: rtl/mem_access_unit.sv
// Request-side front end for the single-port data memory: accepts one load/store at a time,
// range-checks the word address, absorbs the one-cycle read latency and returns a response.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [15:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [15:0]           mem_write_data,
    output logic                  mem_write_enable,
    input  logic [15:0]           mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE,
        RESP
    } state_t;

    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_t state;
    state_t next_state;
    logic   accept;
    logic   in_range;

    assign accept   = req_valid && (state == IDLE);
    assign in_range = ({1'b0, req_addr} < DEPTH_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // All handshake and memory strobes are pure state decodes, so they never glitch on request inputs.
    always_comb begin
        next_state       = state;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_write_enable = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (accept) begin
                    if (!in_range) begin
                        next_state = RESP;
                    end else if (req_write) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            WRITE: begin
                mem_write_enable = 1'b1;
                next_state       = RESP;
            end
            READ: begin
                next_state = CAPTURE;
            end
            CAPTURE: begin
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Address and write data are captured only on accept and held for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_address    <= '0;
            mem_write_data <= '0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
        end else if (accept) begin
            mem_address    <= req_addr;
            mem_write_data <= req_wdata;
            resp_rdata     <= '0;
            resp_error     <= !in_range;
        end else if (state == CAPTURE) begin
            resp_rdata <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural single-port memory
// that registers its read data one cycle after the address is presented.
module tb_mem_access_unit;

    localparam int ADDR_WIDTH = 8;
    localparam int MEM_DEPTH  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [15:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [15:0]           resp_rdata;
    logic                  resp_error;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [15:0]           mem_write_data;
    logic                  mem_write_enable;
    logic [15:0]           mem_read_data;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int we_cycles = 0;

    logic [15:0] mem [256];
    logic        mem_clear = 1'b0;

    mem_access_unit #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_write_enable) we_cycles <= we_cycles + 1;
    end

    // Memory model; the clear pulse also seeds the known prior contents used by the tests.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[1] <= 16'h5555;
            mem[3] <= 16'h1234;
        end else if (mem_write_enable) begin
            mem[mem_address] <= mem_write_data;
        end
        mem_read_data <= mem[mem_address];
    end

    task automatic do_accept(input logic w, input logic [ADDR_WIDTH-1:0] a,
                             input logic [15:0] d, input logic hold);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            failures++;
            $display("[TB] FAIL accept_timeout: req_ready stayed %0b, required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = hold;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        mem_clear  = 1'b1;
        @(posedge clk); #1;
        mem_clear = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, resp_valid, mem_write_enable, resp_error} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b, required 0000",
                     {req_ready, resp_valid, mem_write_enable, resp_error});
        end
        checks++;
        if ({mem_address, mem_write_data, resp_rdata} !== 40'h0) begin
            failures++;
            $display("[TB] FAIL reset_regs: got addr=%0h wdata=%0h rdata=%0h, required all 0",
                     mem_address, mem_write_data, resp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready: got %0b, required 1", req_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat;
        do_accept(1'b1, 8'd1, 16'hAAAA, 1'b0);
        checks++;
        if (mem_write_enable !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midwr_we_high: got %0b, required 1", mem_write_enable);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_write_enable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midwr_we_async_drop: got %0b, required 0", mem_write_enable);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({resp_valid, req_ready, resp_error} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL midwr_flags: got %b, required 010", {resp_valid, req_ready, resp_error});
        end
        checks++;
        if ({mem_address, mem_write_data, resp_rdata} !== 40'h0) begin
            failures++;
            $display("[TB] FAIL midwr_regs: got addr=%0h wdata=%0h rdata=%0h, required all 0",
                     mem_address, mem_write_data, resp_rdata);
        end
        checks++;
        if (mem[1] !== 16'h5555) begin
            failures++;
            $display("[TB] FAIL midwr_mem_unchanged: got %0h, required 5555", mem[1]);
        end
        do_accept(1'b0, 8'd1, 16'h0000, 1'b0);
        wait_resp(lat);
        checks++;
        if (lat !== 2 || resp_rdata !== 16'h5555 || resp_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midwr_reload: got lat=%0d rdata=%0h err=%0b, required lat=2 rdata=5555 err=0",
                     lat, resp_rdata, resp_error);
        end
    endtask

    task automatic test_store_load();
        int lat;
        do_accept(1'b1, 8'd2, 16'hBEEF, 1'b0);
        checks++;
        if (mem_write_enable !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL store_write_cycle: got we=%0b rv=%0b, required we=1 rv=0",
                     mem_write_enable, resp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_write_enable !== 1'b0 || resp_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL store_resp_cycle: got we=%0b rv=%0b, required we=0 rv=1",
                     mem_write_enable, resp_valid);
        end
        checks++;
        if (resp_rdata !== 16'h0000 || resp_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL store_resp_data: got rdata=%0h err=%0b, required 0 0", resp_rdata, resp_error);
        end
        checks++;
        if (mem[2] !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL store_mem: got %0h, required beef", mem[2]);
        end
        do_accept(1'b0, 8'd2, 16'h0000, 1'b0);
        wait_resp(lat);
        checks++;
        if (lat !== 2 || resp_rdata !== 16'hBEEF || resp_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_after_store: got lat=%0d rdata=%0h err=%0b, required lat=2 rdata=beef err=0",
                     lat, resp_rdata, resp_error);
        end
    endtask

    task automatic test_out_of_range();
        int we0;
        we0 = we_cycles;
        do_accept(1'b0, 8'd4, 16'h0000, 1'b0);
        checks++;
        if ({resp_valid, resp_error} !== 2'b11 || resp_rdata !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL oor_load: got rv=%0b err=%0b rdata=%0h, required rv=1 err=1 rdata=0",
                     resp_valid, resp_error, resp_rdata);
        end
        do_accept(1'b1, 8'hFF, 16'h1111, 1'b0);
        checks++;
        if ({resp_valid, resp_error} !== 2'b11 || resp_rdata !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL oor_store: got rv=%0b err=%0b rdata=%0h, required rv=1 err=1 rdata=0",
                     resp_valid, resp_error, resp_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (we_cycles !== we0) begin
            failures++;
            $display("[TB] FAIL oor_no_write: got %0d write cycles, required 0", we_cycles - we0);
        end
        checks++;
        if ({mem[0], mem[1], mem[2], mem[3], mem[255]} !== {16'h0000, 16'h5555, 16'hBEEF, 16'h1234, 16'h0000}) begin
            failures++;
            $display("[TB] FAIL oor_mem_contents: got %0h %0h %0h %0h %0h, required 0 5555 beef 1234 0",
                     mem[0], mem[1], mem[2], mem[3], mem[255]);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        resp_ready = 1'b0;
        do_accept(1'b0, 8'd3, 16'h0000, 1'b1);
        req_write = 1'b1;
        req_addr  = 8'd0;
        req_wdata = 16'h7777;
        wait_resp(lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("[TB] FAIL bp_latency: got %0d, required 2", lat);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 16'h1234 || resp_error !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d]: got rv=%0b rdata=%0h err=%0b, required rv=1 rdata=1234 err=0",
                         i, resp_valid, resp_rdata, resp_error);
            end
            checks++;
            if (req_ready !== 1'b0 || mem_address !== 8'd3) begin
                failures++;
                $display("[TB] FAIL bp_no_accept[%0d]: got ready=%0b addr=%0h, required ready=0 addr=3",
                         i, req_ready, mem_address);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_address !== 8'd3) begin
            failures++;
            $display("[TB] FAIL bp_retire: got rv=%0b ready=%0b addr=%0h, required rv=0 ready=1 addr=3",
                     resp_valid, req_ready, mem_address);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_address !== 8'd0 || mem_write_enable !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_held_accept: got addr=%0h we=%0b, required addr=0 we=1",
                     mem_address, mem_write_enable);
        end
        wait_resp(lat);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] tp_data [4];
        int          acc [8];
        int          lat;
        int          want;
        tp_data[0] = 16'hC0DE;
        tp_data[1] = 16'hF00D;
        tp_data[2] = 16'h0BAD;
        tp_data[3] = 16'hCAFE;
        resp_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            do_accept((t < 4), ADDR_WIDTH'(t % 4), tp_data[t % 4], 1'b1);
            acc[t] = cycle;
            wait_resp(lat);
            if (t > 0) begin
                want = (t <= 4) ? 3 : 4;
                checks++;
                if (acc[t] - acc[t-1] !== want) begin
                    failures++;
                    $display("[TB] FAIL b2b_interval[%0d]: got %0d, required %0d", t, acc[t] - acc[t-1], want);
                end
            end
            if (t >= 4) begin
                checks++;
                if (resp_rdata !== tp_data[t-4] || resp_error !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL b2b_rdata[%0d]: got %0h err=%0b, required %0h err=0",
                             t, resp_rdata, resp_error, tp_data[t-4]);
                end
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_store_load();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Request-side front end for the single-port data `memory` block. It accepts one load or store at a time from the CPU datapath over a valid/ready handshake and range-checks the word address. It drives the memory's address, write-data and write-enable pins, absorbs the memory's one-cycle registered read latency, and returns data or an error on a valid/ready response channel.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: width of word addresses. Must match the memory's `ADDR_WIDTH`.
- `MEM_DEPTH`, 4: number of implemented memory words. Must satisfy 1 <= `MEM_DEPTH` <= 2**`ADDR_WIDTH`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  16  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  16  load data; 0 for stores and errors.
- `resp_error`  out  1  address was out of range.
- `mem_address`  out  ADDR_WIDTH  to memory `address`.
- `mem_write_data`  out  16  to memory `write_data`.
- `mem_write_enable`  out  1  to memory `write_enable`.
- `mem_read_data`  in  16  from memory `read_data`.

## Operation
- State machine states: IDLE, WRITE, READ, CAPTURE, RESP.
- IDLE
  - `req_ready`=1.
  - A request is accepted when `req_valid && req_ready` at a rising edge.
  - On accept, register `req_addr` into `mem_address` and `req_wdata` into `mem_write_data`.
  - On accept, clear `resp_rdata` and `resp_error`.
- Range check at accept: the address is in range only if `req_addr` < `MEM_DEPTH`.
  - Out of range: go to RESP with `resp_error`=1. No memory cycle is issued.
- In-range store: go to WRITE.
- In-range load: go to READ.
- WRITE: `mem_write_enable`=1 for exactly this one cycle. Then go to RESP.
- READ: `mem_write_enable`=0 and the address is held; the memory samples the read at the next edge. Then go to CAPTURE.
- CAPTURE: `mem_read_data` is valid. At the edge, `resp_rdata` <= `mem_read_data`. Then go to RESP.
- RESP
  - `resp_valid`=1. `resp_rdata` and `resp_error` are held stable.
  - On `resp_valid && resp_ready`, return to IDLE.
  - While `resp_ready`=0, stay in RESP indefinitely.
- `mem_write_enable` is 1 only in WRITE. It is a decode of the state register, so it is glitch-free with respect to request inputs.
- `mem_address` and `mem_write_data` change only on accept.
- Single outstanding transaction. `req_ready`=0 in every state except IDLE, so a request and a response retirement never happen on the same edge.

## Timing
- Reset values:
  - state IDLE.
  - `mem_address`, `mem_write_data`, `resp_rdata` all 0.
  - `resp_error`, `resp_valid`, `mem_write_enable` all 0.
  - `req_ready` is forced 0 while `rst`=1; it goes to 1 in the first cycle after deassertion.
- Accept edge is E0.
  - Store: WRITE during E0..E1; memory writes at E1; `resp_valid` rises after E1.
  - Load: READ during E0..E1; CAPTURE during E1..E2; `resp_valid` rises after E2.
  - Error: `resp_valid` rises after E0.
- Minimum accept-to-accept interval with `resp_ready` held at 1:
  - load: 4 cycles.
  - store: 3 cycles.
  - error: 2 cycles.
- Reset mid-operation:
  - The transaction is abandoned and the FSM returns to IDLE.
  - `mem_write_enable` drops asynchronously.
  - If `rst` is high at the WRITE-cycle edge, no write occurs.
  - No response is produced.
- Back-to-back store then load to the same address returns the new data. The store completes at E1, before the load can be accepted.
- Boundary addresses: `MEM_DEPTH-1` is legal. `MEM_DEPTH` and all addresses up to `2**ADDR_WIDTH-1` are errors.

## Test plan
- Reset:
  - Assert `rst` mid-WRITE -> `mem_write_enable` falls immediately.
  - A later load of that address returns its prior value.
  - All outputs are at their reset values.
- Store then load, `MEM_DEPTH`=4:
  - Store 0xBEEF to addr 2 -> `mem_write_enable` is high exactly 1 cycle; `resp_valid` rises 1 cycle after accept with `resp_rdata`=0, `resp_error`=0.
  - Then load addr 2 -> `resp_valid` rises 2 cycles after accept with `resp_rdata`=0xBEEF.
- Out of range:
  - Load addr 4 -> `resp_error`=1 and `resp_rdata`=0, 0 cycles after accept. `mem_write_enable` is never asserted.
  - Store addr 0xFF -> same, and the memory contents are unchanged.
- Backpressure:
  - Load addr 3 (holding 0x1234) with `resp_ready`=0 for 5 cycles -> `resp_valid` and `resp_rdata`=0x1234 are stable throughout.
  - `req_ready` stays 0 and a held `req_valid` is not accepted until the cycle after retirement.
- Throughput: stream 4 stores to addrs 0..3, then 4 loads, with `resp_ready`=1 -> accept intervals are 3 cycles for stores and 4 cycles for loads, and the data reads back in order.
